// File: rtl/spike_filter_serializer.sv
// Packs one filter-state update into two PC-bound words (low half, then high half).
// A single holding register plus a 3-state send FSM gives one record per two output cycles.
module spike_filter_serializer #(
  parameter int          Nfilts  = 10,
  parameter int          Nstate  = 27,
  parameter logic [7:0]  CODE_LO = 8'd12,
  parameter logic [7:0]  CODE_HI = 8'd13,
  parameter int          Ncount  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [Nfilts-1:0] in_filt_idx,
  input  logic [Nstate-1:0] in_filt_state,
  input  logic              in_v,
  output logic              in_a,
  output logic [7:0]        out_code,
  output logic [23:0]       out_payload,
  output logic              out_v,
  input  logic              out_a,
  output logic [Ncount-1:0] records_sent
);

  typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

  state_t      state, state_nxt;
  logic [47:0] hold;
  logic [47:0] rec;
  logic        cap, cnt;

  assign rec = 48'({in_filt_state, in_filt_idx});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      hold         <= '0;
      records_sent <= '0;
    end else begin
      state <= state_nxt;
      if (cap) hold <= rec;
      if (cnt) records_sent <= records_sent + 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_a        = 1'b0;
    out_v       = 1'b0;
    out_code    = '0;
    out_payload = '0;
    cap         = 1'b0;
    cnt         = 1'b0;
    unique case (state)
      IDLE: begin
        in_a = 1'b1;
        if (in_v) begin
          cap       = 1'b1;
          state_nxt = SEND_LO;
        end
      end
      SEND_LO: begin
        out_v       = 1'b1;
        out_code    = CODE_LO;
        out_payload = hold[23:0];
        if (out_a) state_nxt = SEND_HI;
      end
      SEND_HI: begin
        out_v       = 1'b1;
        out_code    = CODE_HI;
        out_payload = hold[47:24];
        // Accepting the next record only as the high word leaves keeps the pair contiguous.
        in_a        = out_a;
        if (out_a) begin
          cnt = 1'b1;
          if (in_v) begin
            cap       = 1'b1;
            state_nxt = SEND_LO;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spike_filter_serializer.sv
// Directed bench for spike_filter_serializer: queue-based word model checked every cycle,
// plus hand-computed word values, counter values and reset behaviour.
module tb_spike_filter_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  in_filt_idx;
  logic [26:0] in_filt_state;
  logic        in_v, out_a;
  logic        in_a, out_v, in_a4, out_v4;
  logic [7:0]  out_code, out_code4;
  logic [23:0] out_payload, out_payload4;
  logic [15:0] records_sent;
  logic [3:0]  records_sent4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_filter_serializer dut (
    .clk(clk), .reset_n(reset_n), .in_filt_idx(in_filt_idx), .in_filt_state(in_filt_state),
    .in_v(in_v), .in_a(in_a), .out_code(out_code), .out_payload(out_payload),
    .out_v(out_v), .out_a(out_a), .records_sent(records_sent));

  spike_filter_serializer #(.Ncount(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_filt_idx(in_filt_idx), .in_filt_state(in_filt_state),
    .in_v(in_v), .in_a(in_a4), .out_code(out_code4), .out_payload(out_payload4),
    .out_v(out_v4), .out_a(out_a), .records_sent(records_sent4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: every accepted record owes two words in order; nothing else is ever owed.
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  int          model_cnt = 0;
  int          vcyc = 0;
  bit          armed = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_word;

  always @(negedge clk) begin
    logic        exp_in_a;
    logic [31:0] w;
    logic [47:0] r;
    if (armed) begin
      exp_in_a = (exp_q.size() == 0) || (exp_q.size() == 1 && out_a);
      chk("out_v", out_v, exp_q.size() != 0);
      chk("in_a", in_a, exp_in_a);
      chk("out_v4", out_v4, exp_q.size() != 0);
      chk("in_a4", in_a4, exp_in_a);
      chk("records_sent", records_sent, model_cnt % 65536);
      chk("records_sent4", records_sent4, model_cnt % 16);
      if (exp_q.size() != 0) begin
        chk("word", {out_code, out_payload}, exp_q[0]);
        chk("word4", {out_code4, out_payload4}, exp_q[0]);
      end
      if (prev_stall) chk("stall_hold", {out_code, out_payload}, prev_word);
      if (out_v) vcyc++;
    end
    prev_stall = out_v && !out_a && reset_n;
    prev_word  = {out_code, out_payload};
    if (!reset_n) begin
      exp_q.delete();
      model_cnt = 0;
      armed = 1;
    end else if (armed) begin
      if (out_v && out_a) begin
        got.push_back({out_code, out_payload});
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          if (w[31:24] == 8'd13) model_cnt++;
        end
      end
      if (in_v && in_a) begin
        r = ({21'b0, in_filt_state} << 10) | {38'b0, in_filt_idx};
        exp_q.push_back({8'd12, r[23:0]});
        exp_q.push_back({8'd13, r[47:24]});
      end
    end
  end

  task automatic put(input logic [9:0] i, input logic [26:0] s);
    int n = 0;
    in_filt_idx = i; in_filt_state = s; in_v = 1'b1;
    do begin @(negedge clk); n++; end while (!in_a && n < 50);
    if (!in_a) chk("put_timeout", in_a, 1'b1);
    @(posedge clk); #1;
    in_v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin @(negedge clk); n++; end while (out_v && n < 100);
    if (out_v) chk("drain_timeout", out_v, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic chk_word(input string name, input int idx, input logic [31:0] exp);
    if (idx < got.size()) chk(name, got[idx], exp);
    else begin
      checks++; errors++;
      $display("FAIL %s actual=missing required=%h", name, exp);
    end
  endtask

  initial begin
    int base, v0;
    reset_n = 1'b0; in_v = 1'b0; in_filt_idx = '0; in_filt_state = '0; out_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_out_v", out_v, 1'b0);
    chk("rst_in_a", in_a, 1'b1);
    chk("rst_code", out_code, 8'd0);
    chk("rst_payload", out_payload, 24'd0);
    chk("rst_count", records_sent, 16'd0);
    @(posedge clk); #1;

    // single record
    base = got.size();
    put(10'h3A5, 27'h5ABCDEF);
    drain();
    chk_word("single_lo", base, {8'd12, 24'h37BFA5});
    chk_word("single_hi", base + 1, {8'd13, 24'h0016AF});
    chk("single_count", records_sent, 16'd1);

    // boundary values
    base = got.size();
    put(10'h000, 27'h0000000);
    put(10'h3FF, 27'h7FFFFFF);
    drain();
    chk_word("zero_lo", base, {8'd12, 24'h000000});
    chk_word("zero_hi", base + 1, {8'd13, 24'h000000});
    chk_word("ones_lo", base + 2, {8'd12, 24'hFFFFFF});
    chk_word("ones_hi", base + 3, {8'd13, 24'h001FFF});
    chk("bound_count", records_sent, 16'd3);

    // back-to-back burst of 8
    base = got.size(); v0 = vcyc;
    for (int k = 0; k < 8; k++) put(10'(k * 37 + 1), 27'(k * 27'h123457));
    drain();
    chk("b2b_words", got.size() - base, 16);
    chk("b2b_vcycles", vcyc - v0, 16);
    chk("b2b_count", records_sent, 16'd11);

    // backpressure on both words, with a new record waiting during the high-word stall
    base = got.size();
    put(10'h155, 27'h2AAAAAA);
    out_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("stall_lo_in_a", in_a, 1'b0);
    @(posedge clk); #1 out_a = 1'b1;
    @(posedge clk); #1 out_a = 1'b0;
    in_filt_idx = 10'h2C3; in_filt_state = 27'h1234567; in_v = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("stall_hi_in_a", in_a, 1'b0);
    @(posedge clk); #1 out_a = 1'b1;
    put(10'h2C3, 27'h1234567);
    drain();
    chk("bp_words", got.size() - base, 4);
    chk_word("bp_a_lo", base, {8'd12, 24'hAAA955});
    chk_word("bp_a_hi", base + 1, {8'd13, 24'h000AAA});
    chk_word("bp_b_lo", base + 2, {8'd12, 24'h159EC3});
    chk_word("bp_b_hi", base + 3, {8'd13, 24'h00048D});
    chk("bp_count", records_sent, 16'd13);

    // reset right after the low word is accepted
    base = got.size();
    put(10'h0F0, 27'h0F0F0F0);
    @(posedge clk); #1;
    reset_n = 1'b0; out_a = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1; out_a = 1'b1;
    @(negedge clk);
    chk("mid_out_v", out_v, 1'b0);
    chk("mid_in_a", in_a, 1'b1);
    chk("mid_code", out_code, 8'd0);
    chk("mid_payload", out_payload, 24'd0);
    chk("mid_count", records_sent, 16'd0);
    repeat (3) @(negedge clk);
    chk("mid_words", got.size() - base, 1);
    @(posedge clk); #1;

    // counter wrap on the 4-bit instance
    for (int k = 0; k < 17; k++) put(10'(k), 27'(k * 3));
    drain();
    chk("wrap_count4", records_sent4, 4'd1);
    chk("wrap_count16", records_sent, 16'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
